// File: rtl/qsys_system_processor_oci_dct_ctrl.sv
// DCT atom packetiser for the OCI trace path.
//
// Collects 2-bit direct-control-transfer atoms into a shift buffer and hands
// them to the trace FIFO as packets through a single valid/ready output slot.
// A packet is emitted when the buffer fills to DEPTH atoms, on a flush request,
// or when tracing is switched off. An atom that arrives in the same cycle as
// the emit is included in that packet, so a full packet is presented one cycle
// after its last atom.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   trc_on            trace enable; a 1->0 transition acts as a flush
//   atom_valid, atom  incoming atom and its qualifier
//   flush             single-cycle request to emit a partial packet
//   pkt_ready         downstream accept
//   pkt_valid         packet presented
//   pkt_data          packed atoms, oldest atom in the most-significant used pair
//   pkt_count         number of atoms in pkt_data
//   dct_buffer        live accumulation buffer
//   dct_count         live atom count
//   atom_drop         one-cycle pulse after an atom was lost to back-pressure
//   drop_count        saturating lost-atom counter (only with DCT_DROP_COUNTER_EN)
//
// Optional feature: define DCT_DROP_COUNTER_EN to add the drop_count output.

module qsys_system_processor_oci_dct_ctrl #(
  parameter int unsigned DEPTH = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               trc_on,
  input  logic               atom_valid,
  input  logic [1:0]         atom,
  input  logic               flush,
  input  logic               pkt_ready,
  output logic               pkt_valid,
  output logic [2*DEPTH-1:0] pkt_data,
  output logic [3:0]         pkt_count,
  output logic [2*DEPTH-1:0] dct_buffer,
  output logic [3:0]         dct_count,
  output logic               atom_drop
`ifdef DCT_DROP_COUNTER_EN
  ,
  output logic [15:0]        drop_count
`endif
);

  localparam int unsigned W         = 2 * DEPTH;
  localparam logic [3:0]  FullCount = 4'(DEPTH);

  typedef enum logic [1:0] {StIdle, StFill, StFullWait, StPresent} state_e;

  state_e         state_q, state_d;
  logic           trc_on_q;
  logic           flush_pend_q, flush_pend_d;
  logic           take, flush_req, slot_free;
  logic [W-1:0]   eff_buf, buf_d, pkt_data_d;
  logic [3:0]     eff_cnt, cnt_d, pkt_count_d;
  logic           pkt_valid_d, drop_d;

  assign take      = atom_valid & trc_on;
  assign flush_req = flush | flush_pend_q | (trc_on_q & ~trc_on);
  assign slot_free = ~pkt_valid | pkt_ready;
  // Buffer and count as they would be with this cycle's atom appended.
  assign eff_buf   = take ? {dct_buffer[W-3:0], atom} : dct_buffer;
  assign eff_cnt   = dct_count + {3'b000, take};

  always_comb begin
    buf_d        = dct_buffer;
    cnt_d        = dct_count;
    pkt_valid_d  = pkt_valid & ~pkt_ready;
    pkt_data_d   = pkt_data;
    pkt_count_d  = pkt_count;
    drop_d       = 1'b0;
    flush_pend_d = flush_pend_q;

    if (state_q == StFullWait) begin
      if (slot_free) begin
        // The stored full packet leaves; a new atom starts the next packet, and
        // a flush arriving with it stays pending for that new atom.
        pkt_valid_d  = 1'b1;
        pkt_data_d   = dct_buffer;
        pkt_count_d  = dct_count;
        buf_d        = take ? {{(W-2){1'b0}}, atom} : '0;
        cnt_d        = take ? 4'd1 : 4'd0;
        flush_pend_d = flush_req & take;
      end else begin
        drop_d       = take;
        flush_pend_d = flush_req;
      end
    end else begin
      buf_d = eff_buf;
      cnt_d = eff_cnt;
      if (((eff_cnt == FullCount) || (flush_req && (eff_cnt != 4'd0))) && slot_free) begin
        pkt_valid_d  = 1'b1;
        pkt_data_d   = eff_buf;
        pkt_count_d  = eff_cnt;
        buf_d        = '0;
        cnt_d        = 4'd0;
        flush_pend_d = 1'b0;
      end else begin
        // A flush with nothing buffered is dropped rather than latched.
        flush_pend_d = flush_req & (eff_cnt != 4'd0);
      end
    end

    if (cnt_d == FullCount) begin
      state_d = StFullWait;
    end else if (pkt_valid_d) begin
      state_d = StPresent;
    end else if (cnt_d != 4'd0) begin
      state_d = StFill;
    end else begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      trc_on_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      dct_buffer   <= '0;
      dct_count    <= 4'd0;
      pkt_valid    <= 1'b0;
      pkt_data     <= '0;
      pkt_count    <= 4'd0;
      atom_drop    <= 1'b0;
    end else begin
      state_q      <= state_d;
      trc_on_q     <= trc_on;
      flush_pend_q <= flush_pend_d;
      dct_buffer   <= buf_d;
      dct_count    <= cnt_d;
      pkt_valid    <= pkt_valid_d;
      pkt_data     <= pkt_data_d;
      pkt_count    <= pkt_count_d;
      atom_drop    <= drop_d;
    end
  end

`ifdef DCT_DROP_COUNTER_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= 16'd0;
    end else if (drop_d && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qsys_system_processor_oci_dct_ctrl.sv
module tb_qsys_system_processor_oci_dct_ctrl;

  localparam int DEPTH = 15;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               trc_on;
  logic               atom_valid;
  logic [1:0]         atom;
  logic               flush;
  logic               pkt_ready;
  logic               pkt_valid;
  logic [2*DEPTH-1:0] pkt_data;
  logic [3:0]         pkt_count;
  logic [2*DEPTH-1:0] dct_buffer;
  logic [3:0]         dct_count;
  logic               atom_drop;
`ifdef DCT_DROP_COUNTER_EN
  logic [15:0]        drop_count;
`endif

  qsys_system_processor_oci_dct_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .trc_on     (trc_on),
    .atom_valid (atom_valid),
    .atom       (atom),
    .flush      (flush),
    .pkt_ready  (pkt_ready),
    .pkt_valid  (pkt_valid),
    .pkt_data   (pkt_data),
    .pkt_count  (pkt_count),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .atom_drop  (atom_drop)
`ifdef DCT_DROP_COUNTER_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  cnt;
  } pkt_t;

  pkt_t exp_q[$];

  // Reference model: atoms held in a queue, output slot as a busy flag.
  logic [1:0] mq[$];
  bit         m_busy;
  bit         m_pend;
  bit         m_trc_q;
  bit         m_drop;
  int         m_drops;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack_mq();
    logic [63:0] v = 64'd0;
    foreach (mq[i]) v = (v << 2) | 64'(mq[i]);
    return v;
  endfunction

  task automatic emit_mq();
    pkt_t p;
    p.data = pack_mq();
    p.cnt  = 4'(mq.size());
    exp_q.push_back(p);
    mq.delete();
  endtask

  task automatic model_edge(input bit av, input logic [1:0] a, input bit fl, input bit rdy,
                            input bit trc);
    bit take    = av && trc;
    bit fr      = fl || m_pend || (m_trc_q && !trc);
    bit free    = !m_busy || rdy;
    bit emitted = 0;
    m_drop = 0;
    if (mq.size() == DEPTH) begin
      if (free) begin
        emit_mq();
        emitted = 1;
        if (take) mq.push_back(a);
        m_pend = fr && take;
      end else begin
        if (take) begin
          m_drop = 1;
          if (m_drops < 65535) m_drops++;
        end
        m_pend = fr;
      end
    end else begin
      if (take) mq.push_back(a);
      if ((mq.size() == DEPTH || (fr && mq.size() > 0)) && free) begin
        emit_mq();
        emitted = 1;
        m_pend  = 0;
      end else begin
        m_pend = fr && (mq.size() > 0);
      end
    end
    m_busy  = (m_busy && !rdy) || emitted;
    m_trc_q = trc;
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_busy  = 0;
    m_pend  = 0;
    m_trc_q = 0;
    m_drop  = 0;
    m_drops = 0;
  endtask

  task automatic step(input bit av, input logic [1:0] a, input bit fl, input bit rdy,
                      input bit trc);
    atom_valid = av;
    atom       = a;
    flush      = fl;
    pkt_ready  = rdy;
    trc_on     = trc;
    model_edge(av, a, fl, rdy, trc);
    @(posedge clk);
    #1;
    check("dct_count", 64'(dct_count), 64'(mq.size()));
    check("dct_buffer", 64'(dct_buffer), pack_mq());
    check("pkt_valid", 64'(pkt_valid), 64'(m_busy));
    check("atom_drop", 64'(atom_drop), 64'(m_drop));
`ifdef DCT_DROP_COUNTER_EN
    check("drop_count", 64'(drop_count), 64'(m_drops));
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pkt_valid"}, 64'(pkt_valid), 64'd0);
    check({tag, "_pkt_data"}, 64'(pkt_data), 64'd0);
    check({tag, "_pkt_count"}, 64'(pkt_count), 64'd0);
    check({tag, "_dct_buffer"}, 64'(dct_buffer), 64'd0);
    check({tag, "_dct_count"}, 64'(dct_count), 64'd0);
    check({tag, "_atom_drop"}, 64'(atom_drop), 64'd0);
`ifdef DCT_DROP_COUNTER_EN
    check({tag, "_drop_count"}, 64'(drop_count), 64'd0);
`endif
  endtask

  // Scoreboard monitor: every handshake consumes one expected packet.
  initial begin
    pkt_t e;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && pkt_valid === 1'b1 && pkt_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pkt_unexpected actual=count %0d data %0h required=no packet",
                   pkt_count, pkt_data);
        end else begin
          e = exp_q.pop_front();
          check("pkt_data", 64'(pkt_data), e.data);
          check("pkt_count", 64'(pkt_count), 64'(e.cnt));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    trc_on     = 1'b0;
    atom_valid = 1'b0;
    atom       = 2'b00;
    flush      = 1'b0;
    pkt_ready  = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Full packet of 15 atoms 2'b01.
    for (int i = 0; i < DEPTH; i++) step(1, 2'b01, 0, 1, 1);
    check("full_pkt_valid", 64'(pkt_valid), 64'd1);
    check("full_pkt_data", 64'(pkt_data), 64'h15555555);
    check("full_pkt_count", 64'(pkt_count), 64'd15);
    check("full_dct_count", 64'(dct_count), 64'd0);

    // Partial flush with a simultaneous atom.
    step(1, 2'b11, 0, 1, 1);
    step(1, 2'b10, 0, 1, 1);
    step(1, 2'b01, 1, 1, 1);
    check("flush_pkt_count", 64'(pkt_count), 64'd3);
    check("flush_pkt_data", 64'(pkt_data[5:0]), 64'b111001);

    // Back-pressure: 30 atoms fill the slot and the buffer, the 31st is lost.
    step(0, 2'b00, 0, 1, 1);
    for (int i = 0; i < 2 * DEPTH; i++) step(1, 2'(i), 0, 0, 1);
    check("bp_pkt_count", 64'(pkt_count), 64'd15);
    check("bp_dct_count", 64'(dct_count), 64'd15);
    step(1, 2'b11, 0, 0, 1);
    check("bp_atom_drop", 64'(atom_drop), 64'd1);
    check("bp_dct_count_held", 64'(dct_count), 64'd15);
`ifdef DCT_DROP_COUNTER_EN
    check("bp_drop_count", 64'(drop_count), 64'd1);
`endif
    step(0, 2'b00, 0, 1, 1);
    step(0, 2'b00, 0, 1, 1);

    // Deferred flush while the slot is busy.
    for (int i = 0; i < DEPTH; i++) step(1, 2'(i + 1), 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 2'(3 - i), 0, 0, 1);
    step(0, 2'b00, 1, 0, 1);
    check("defer_held_count", 64'(pkt_count), 64'd15);
    check("defer_dct_count", 64'(dct_count), 64'd4);
    step(0, 2'b00, 0, 1, 1);
    check("defer_pkt_valid", 64'(pkt_valid), 64'd1);
    check("defer_pkt_count", 64'(pkt_count), 64'd4);
    step(0, 2'b00, 0, 1, 1);

    // Zero-count flush.
    step(0, 2'b00, 1, 1, 1);
    check("zero_flush_valid", 64'(pkt_valid), 64'd0);

    // trc_on fall flushes 7 atoms.
    for (int i = 0; i < 7; i++) step(1, 2'(i), 0, 1, 1);
    step(0, 2'b00, 0, 1, 0);
    check("trc_fall_valid", 64'(pkt_valid), 64'd1);
    check("trc_fall_count", 64'(pkt_count), 64'd7);
    step(0, 2'b00, 0, 1, 1);

    // Asynchronous reset with 9 atoms buffered.
    for (int i = 0; i < 9; i++) step(1, 2'(i + 2), 0, 1, 1);
    check("pre_reset_count", 64'(dct_count), 64'd9);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Randomised traffic.
    for (int i = 0; i < 2500; i++) begin
      step(($urandom_range(0, 9) < 7), 2'($urandom), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) != 0));
    end

    // Drain whatever is left.
    step(0, 2'b00, 1, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 2'b00, 0, 1, 1);
    check("drain_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("drain_pkt_valid", 64'(pkt_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qsys_system_processor_oci_dct_ctrl.md
QSYS_SYSTEM_PROCESSOR_OCI_DCT_CTRL -- requirements
Module: qsys_system_processor_oci_dct_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 15, meaning the number of 2-bit DCT atoms per packet; the legal range is 2..15.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: port clk, input, 1 bit, is the sole clock with all state on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit, the asynchronous active-low reset.
REQ-004 SHALL have port trc_on, input, 1 bit, the trace enable.
REQ-005 SHALL have port atom_valid, input, 1 bit, which qualifies atom.
REQ-006 SHALL have port atom, input, 2 bits, the direct-control-transfer atom.
REQ-007 SHALL have port flush, input, 1 bit, a single-cycle request to emit a partial packet.
REQ-008 SHALL have port pkt_ready, input, 1 bit, the downstream trace-FIFO accept signal.
REQ-009 SHALL have port pkt_valid, output, 1 bit, which means a packet is presented.
REQ-010 SHALL have port pkt_data, output, 2*DEPTH bits, the packed atoms, with the oldest atom in the most-significant used pair.
REQ-011 SHALL have port pkt_count, output, 4 bits, the number of atoms in pkt_data.
REQ-012 SHALL have port dct_buffer, output, 2*DEPTH bits, the live accumulation buffer.
REQ-013 SHALL have port dct_count, output, 4 bits, the live atom count.
REQ-014 SHALL have port atom_drop, output, 1 bit, a single-cycle pulse on a lost atom.

Function
REQ-015 SHALL accept an atom when atom_valid=1, trc_on=1 and no drop condition applies: dct_buffer <= {dct_buffer[2*DEPTH-3:0], atom} and dct_count increments.
REQ-016 SHALL emit a packet when dct_count reaches DEPTH (an auto-emit) or when flush=1 with a nonzero effective count: it copies the buffer and count into pkt_data/pkt_count, sets pkt_valid, and clears dct_buffer/dct_count in the same edge.
REQ-017 SHALL perform an emit only when the output slot is free, i.e. pkt_valid=0 or pkt_valid&pkt_ready=1 in that cycle; emits otherwise wait.
REQ-018 SHALL assert pkt_valid on the cycle after the edge at which the DEPTH-th atom is accepted, so an auto-emit has 1-cycle latency.
REQ-019 SHALL, when an atom and flush arrive in the same cycle, include the atom in the flushed packet (effective count = dct_count+1).
REQ-020 SHALL ignore a flush when the effective count is 0; no zero-length packet is ever produced.
REQ-021 SHALL hold pkt_valid, pkt_data and pkt_count stable until the cycle in which pkt_valid&pkt_ready=1.
REQ-022 SHALL, when dct_count=DEPTH and the slot is occupied with pkt_ready=0, discard an arriving valid atom, pulse atom_drop for 1 cycle, and leave the buffer unchanged.
REQ-023 SHALL, when a pending flush cannot emit because the slot is busy, latch it and honor it on the first cycle the slot is free.
REQ-024 SHALL treat a 1->0 transition of trc_on as an implicit flush, and SHALL ignore atoms while trc_on=0.
REQ-025 SHALL use FSM states IDLE (count=0, slot empty), FILL (0<count<DEPTH), FULL_WAIT (count=DEPTH, slot busy) and PRESENT (slot busy, count<DEPTH); transitions follow REQ-015..REQ-024 only.
REQ-026 SHALL never let dct_count exceed DEPTH.

Reset
REQ-027 SHALL, on reset_n=0 at any time including mid-packet, immediately drive pkt_valid=0, pkt_data=0, pkt_count=0, dct_buffer=0, dct_count=0, atom_drop=0, clear any latched flush, and enter IDLE.
REQ-028 SHALL discard in-flight atoms at reset; operation resumes on the first clk edge after reset_n deasserts.

Configuration
REQ-029 SHALL, with macro DCT_DROP_COUNTER_EN defined, add output drop_count (16 bits), which increments on each atom_drop pulse, saturates at 0xFFFF, and resets to 0.
REQ-030 SHALL, without DCT_DROP_COUNTER_EN, omit the port and the counter logic, leaving all other behaviour identical.

Verification
REQ-031 SHALL cover a full packet: DEPTH=15, pkt_ready=1, 15 consecutive atoms 2'b01 -> pkt_valid=1 one cycle after the 15th, pkt_data=30'h15555555, pkt_count=15, dct_count=0.
REQ-032 SHALL cover a partial flush: atoms 2'b11, 2'b10, then flush with a simultaneous atom 2'b01 -> pkt_count=3, pkt_data[5:0]=6'b111001.
REQ-033 SHALL cover back-pressure: pkt_ready=0, 30 atoms then 1 more -> the first packet is held, the buffer is full with 15, the 31st atom gives an atom_drop pulse, and (with DCT_DROP_COUNTER_EN) drop_count=1.
REQ-034 SHALL cover a deferred flush: slot busy, flush with count=4, then pkt_ready=1 -> the first packet is accepted and the next cycle presents pkt_count=4.
REQ-035 SHALL cover trc_on fall and reset: trc_on 1->0 with count=7 -> a 7-atom packet is emitted; reset_n=0 while count=9 -> all outputs are 0 asynchronously.
REQ-036 SHALL cover the zero-count flush: flush with count=0 -> pkt_valid remains 0.
